fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 36 +++
 rtl/fifo_ptr_sync.sv | 44 ++++
 rtl/fifo_wr_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_wr_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for both sides of the asynchronous FIFO:
//   - DEFAULT_ADDR_WIDTH / DEFAULT_SYNC_STAGES : default geometry
//   - ptr_t      : pointer type (DEFAULT_ADDR_WIDTH+1 bits, one wrap bit)
//   - bin2gray() : binary -> Gray conversion
//   - gray2bin() : Gray -> binary conversion
// The conversion functions work on a wide container type so that blocks with
// any pointer width can call them; callers zero-extend on the way in and
// truncate on the way out.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 3;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int PTR_WIDTH           = DEFAULT_ADDR_WIDTH + 1;
    localparam int MAX_PTR_WIDTH       = 32;

    typedef logic [PTR_WIDTH-1:0]     ptr_t;
    typedef logic [MAX_PTR_WIDTH-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
        for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// -----------------------------------------------------------------------------
// fifo_ptr_sync
// Multi-flop synchronizer for a Gray-coded pointer crossing into the clk
// domain. Used by both the write side (read pointer) and the read side
// (write pointer).
// Parameters:
//   WIDTH  : pointer width
//   STAGES : number of flops in the chain (2 or more)
// Ports:
//   clk : destination-domain clock
//   rst : asynchronous active-high reset, clears every stage
//   d   : pointer from the other clock domain
//   q   : synchronized pointer (last stage)
// -----------------------------------------------------------------------------
module fifo_ptr_sync #(
    parameter int WIDTH  = fifo_pkg::PTR_WIDTH,
    parameter int STAGES = fifo_pkg::DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // NOTE: this small array is a flop chain, not a RAM, so every stage is reset;
    // a stale pointer left in any stage after reset would be seen as real data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of an asynchronous FIFO: owns the write pointer,
// generates the memory write strobe/address, publishes the Gray write pointer
// to the read domain and produces full / overflow (and optionally almost-full)
// flags from the synchronized read pointer.
// Parameters:
//   ADDR_WIDTH   : memory address width (depth = 2**ADDR_WIDTH)
//   SYNC_STAGES  : flops in the read-pointer synchronizer (>= 2)
//   AFULL_THRESH : occupancy at which w_afull asserts (1 .. depth-1)
// Ports:
//   w_clk      : write-domain clock
//   w_rst      : asynchronous active-high reset
//   w_inc      : write request
//   gray_r_ptr : Gray read pointer from the read domain (asynchronous)
//   w_addr     : memory write address
//   gray_w_ptr : registered Gray write pointer to the read domain
//   w_en       : memory write strobe (w_inc and not full)
//   w_full     : registered full flag
//   w_afull    : registered almost-full flag (only with FIFO_AFULL_EN)
//   w_ovf      : sticky overflow flag, cleared only by reset
// Build option: define FIFO_AFULL_EN to add w_afull and its occupancy logic.
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   gray_r_ptr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   gray_w_ptr,
    output logic                  w_en,
    output logic                  w_full,
`ifdef FIFO_AFULL_EN
    output logic                  w_afull,
`endif
    output logic                  w_ovf
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    typedef logic [PTR_W-1:0] wptr_t;

    // Full when the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its two MSBs inverted.
    localparam wptr_t FULL_FLIP = wptr_t'(3) << (PTR_W - 2);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be 2 or more");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > (2**ADDR_WIDTH) - 1) begin : g_bad_afull
        $error("fifo_wr_ctrl: AFULL_THRESH must be 1 .. depth-1");
    end

    wptr_t w_bin;
    wptr_t w_bin_next;
    wptr_t w_gray_next;
    wptr_t r_gray_sync;
    logic  full_next;

    fifo_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_r_ptr_sync (
        .clk (w_clk),
        .rst (w_rst),
        .d   (gray_r_ptr),
        .q   (r_gray_sync)
    );

    assign w_en   = w_inc & ~w_full;
    assign w_addr = w_bin[ADDR_WIDTH-1:0];

    // NOTE: every signal written here is assigned on every pass, so no latch
    // can be inferred; add a default first if a branch is ever introduced.
    always_comb begin
        w_bin_next  = w_bin + wptr_t'(w_en);
        w_gray_next = wptr_t'(bin2gray(ptr_max_t'(w_bin_next)));
        full_next   = (w_gray_next == (r_gray_sync ^ FULL_FLIP));
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_bin      <= '0;
            gray_w_ptr <= '0;
            w_full     <= 1'b0;
            w_ovf      <= 1'b0;
        end else begin
            w_bin      <= w_bin_next;
            gray_w_ptr <= w_gray_next;
            w_full     <= full_next;
            if (w_inc && w_full) begin
                w_ovf <= 1'b1;
            end
        end
    end

`ifdef FIFO_AFULL_EN
    localparam wptr_t AFULL_LEVEL = wptr_t'(AFULL_THRESH);

    wptr_t r_bin_sync;
    wptr_t occupancy;

    // Occupancy uses the post-write pointer so w_afull has no lag, like w_full.
    // The subtraction wraps naturally modulo 2**PTR_W.
    always_comb begin
        r_bin_sync = wptr_t'(gray2bin(ptr_max_t'(r_gray_sync)));
        occupancy  = w_bin_next - r_bin_sync;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_afull <= 1'b0;
        end else begin
            w_afull <= (occupancy >= AFULL_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Self-checking bench for fifo_wr_ctrl. The reference model counts accepted
// writes and reads as plain integers; full / almost-full come from the
// occupancy (writes minus the read count as it was SYNC_STAGES edges ago).
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int AW     = 3;
    localparam int DEPTH  = 2**AW;
    localparam int PW     = AW + 1;
    localparam int S      = 2;
    localparam int THRESH = 6;

    logic          w_clk = 1'b0;
    logic          w_rst = 1'b0;
    logic          w_inc = 1'b0;
    logic [PW-1:0] gray_r_ptr = '0;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] gray_w_ptr;
    logic          w_en;
    logic          w_full;
    logic          w_ovf;
`ifdef FIFO_AFULL_EN
    logic          w_afull;
`endif

    fifo_wr_ctrl #(
        .ADDR_WIDTH   (AW),
        .SYNC_STAGES  (S),
        .AFULL_THRESH (THRESH)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_inc      (w_inc),
        .gray_r_ptr (gray_r_ptr),
        .w_addr     (w_addr),
        .gray_w_ptr (gray_w_ptr),
        .w_en       (w_en),
        .w_full     (w_full),
`ifdef FIFO_AFULL_EN
        .w_afull    (w_afull),
`endif
        .w_ovf      (w_ovf)
    );

    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_wr;
    int   m_rd;
    bit   m_full;
    bit   m_ovf;
    bit   m_afull;
    int   rd_q[$];
    bit   exp_en;
    logic obs_en;

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wr    = 0;
        m_rd    = 0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
        m_afull = 1'b0;
        rd_q.delete();
        repeat (S) rd_q.push_back(0);
    endtask

    // One clock: drive inputs after the falling edge, sample w_en before the
    // rising edge, advance the model at the rising edge, settle 1 time unit.
    task automatic tick(input bit inc);
        int seen;
        @(negedge w_clk);
        w_inc      = inc;
        gray_r_ptr = to_gray(m_rd);
        #1;
        obs_en = w_en;
        exp_en = inc && !m_full;
        @(posedge w_clk);
        seen = rd_q.pop_front();
        rd_q.push_back(m_rd);
        if (inc && m_full) m_ovf = 1'b1;
        if (exp_en) m_wr++;
        m_full  = ((m_wr - seen) == DEPTH);
        m_afull = ((m_wr - seen) >= THRESH);
        #1;
    endtask

    task automatic test_reset();
        w_inc      = 1'b0;
        gray_r_ptr = '0;
        model_reset();
        #2 w_rst = 1'b1;
        #3;
        n_checks++; if (w_addr !== '0)     begin n_fail++; $display("FAIL rst_in_addr: got %0d want 0", w_addr); end
        n_checks++; if (gray_w_ptr !== '0) begin n_fail++; $display("FAIL rst_in_gray: got %b want 0000", gray_w_ptr); end
        n_checks++; if (w_full !== 1'b0)   begin n_fail++; $display("FAIL rst_in_full: got %b want 0", w_full); end
        n_checks++; if (w_ovf !== 1'b0)    begin n_fail++; $display("FAIL rst_in_ovf: got %b want 0", w_ovf); end
        @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        n_checks++; if (w_addr !== '0)     begin n_fail++; $display("FAIL rst_out_addr: got %0d want 0", w_addr); end
        n_checks++; if (gray_w_ptr !== '0) begin n_fail++; $display("FAIL rst_out_gray: got %b want 0000", gray_w_ptr); end
        n_checks++; if (w_full !== 1'b0)   begin n_fail++; $display("FAIL rst_out_full: got %b want 0", w_full); end
        n_checks++; if (w_ovf !== 1'b0)    begin n_fail++; $display("FAIL rst_out_ovf: got %b want 0", w_ovf); end
`ifdef FIFO_AFULL_EN
        n_checks++; if (w_afull !== 1'b0)  begin n_fail++; $display("FAIL rst_out_afull: got %b want 0", w_afull); end
`endif
    endtask

    task automatic test_fill();
        m_rd = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (w_addr !== AW'(i)) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, w_addr, i); end
            tick(1'b1);
            n_checks++; if (obs_en !== 1'b1) begin n_fail++; $display("FAIL fill_en[%0d]: got %b want 1", i, obs_en); end
            n_checks++; if (gray_w_ptr !== to_gray(m_wr)) begin n_fail++; $display("FAIL fill_gray[%0d]: got %b want %b", i, gray_w_ptr, to_gray(m_wr)); end
            n_checks++; if (w_full !== m_full) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, w_full, m_full); end
        end
        n_checks++; if (gray_w_ptr !== 4'b1100) begin n_fail++; $display("FAIL fill_final_gray: got %b want 1100", gray_w_ptr); end
        n_checks++; if (w_full !== 1'b1)        begin n_fail++; $display("FAIL fill_final_full: got %b want 1", w_full); end
    endtask

    task automatic test_overflow();
        tick(1'b1);
        n_checks++; if (obs_en !== 1'b0)        begin n_fail++; $display("FAIL ovf_en: got %b want 0", obs_en); end
        n_checks++; if (gray_w_ptr !== 4'b1100) begin n_fail++; $display("FAIL ovf_gray: got %b want 1100", gray_w_ptr); end
        n_checks++; if (w_ovf !== 1'b1)         begin n_fail++; $display("FAIL ovf_set: got %b want 1", w_ovf); end
        repeat (3) tick(1'b0);
        n_checks++; if (w_ovf !== 1'b1)         begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", w_ovf); end
        n_checks++; if (w_full !== 1'b1)        begin n_fail++; $display("FAIL ovf_full_hold: got %b want 1", w_full); end
    endtask

    // Writes are requested throughout; those before full releases must be
    // rejected even though the read pointer has already moved.
    task automatic test_drain_release();
        int  edges;
        bit  released;
        edges    = 0;
        released = 1'b0;
        m_rd     = 1;
        while (!released && edges < S + 1) begin
            tick(1'b1);
            edges++;
            n_checks++; if (obs_en !== 1'b0)   begin n_fail++; $display("FAIL drain_reject[%0d]: got %b want 0", edges, obs_en); end
            n_checks++; if (w_full !== m_full) begin n_fail++; $display("FAIL drain_full[%0d]: got %b want %b", edges, w_full, m_full); end
            if (w_full === 1'b0) released = 1'b1;
        end
        n_checks++; if (!released) begin n_fail++; $display("FAIL drain_release: w_full got 1 want 0 within %0d edges", S + 1); end
        tick(1'b1);
        n_checks++; if (obs_en !== 1'b1)                begin n_fail++; $display("FAIL drain_accept: got %b want 1", obs_en); end
        n_checks++; if (w_full !== 1'b1)                begin n_fail++; $display("FAIL drain_refull: got %b want 1", w_full); end
        n_checks++; if (gray_w_ptr !== to_gray(m_wr))  begin n_fail++; $display("FAIL drain_gray: got %b want %b", gray_w_ptr, to_gray(m_wr)); end
    endtask

    // Reader keeps up with the writer so the pointer laps several times.
    task automatic test_wrap();
        logic [PW-1:0] prev_gray;
        logic [AW-1:0] prev_addr;
        bit            gray_wrapped;
        bit            addr_wrapped;
        gray_wrapped = 1'b0;
        addr_wrapped = 1'b0;
        for (int i = 0; i < 24; i++) begin
            prev_gray = gray_w_ptr;
            prev_addr = w_addr;
            m_rd = m_wr;
            tick(1'b1);
            if (prev_gray == 4'b1000 && gray_w_ptr == 4'b0000) gray_wrapped = 1'b1;
            if (prev_addr == 3'd7 && w_addr == 3'd0) addr_wrapped = 1'b1;
            n_checks++; if (obs_en !== exp_en)              begin n_fail++; $display("FAIL wrap_en[%0d]: got %b want %b", i, obs_en, exp_en); end
            n_checks++; if (w_addr !== AW'(m_wr % DEPTH))   begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, w_addr, m_wr % DEPTH); end
            n_checks++; if (gray_w_ptr !== to_gray(m_wr))   begin n_fail++; $display("FAIL wrap_gray[%0d]: got %b want %b", i, gray_w_ptr, to_gray(m_wr)); end
            n_checks++; if (w_full !== m_full)              begin n_fail++; $display("FAIL wrap_full[%0d]: got %b want %b", i, w_full, m_full); end
        end
        n_checks++; if (!gray_wrapped) begin n_fail++; $display("FAIL wrap_gray_seq: 1000->0000 got not seen want seen"); end
        n_checks++; if (!addr_wrapped) begin n_fail++; $display("FAIL wrap_addr_seq: 7->0 got not seen want seen"); end
        n_checks++; if (w_full !== 1'b0) begin n_fail++; $display("FAIL wrap_no_full: got %b want 0", w_full); end
    endtask

    task automatic test_random();
        bit inc;
        for (int i = 0; i < 300; i++) begin
            inc = ($urandom_range(0, 3) != 0);
            if (m_rd < m_wr && $urandom_range(0, 2) == 0) m_rd++;
            tick(inc);
            n_checks++; if (obs_en !== exp_en)            begin n_fail++; $display("FAIL rnd_en[%0d]: got %b want %b", i, obs_en, exp_en); end
            n_checks++; if (w_addr !== AW'(m_wr % DEPTH)) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, w_addr, m_wr % DEPTH); end
            n_checks++; if (gray_w_ptr !== to_gray(m_wr)) begin n_fail++; $display("FAIL rnd_gray[%0d]: got %b want %b", i, gray_w_ptr, to_gray(m_wr)); end
            n_checks++; if (w_full !== m_full)            begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, w_full, m_full); end
            n_checks++; if (w_ovf !== m_ovf)              begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, w_ovf, m_ovf); end
`ifdef FIFO_AFULL_EN
            n_checks++; if (w_afull !== m_afull)          begin n_fail++; $display("FAIL rnd_afull[%0d]: got %b want %b", i, w_afull, m_afull); end
`endif
        end
    endtask

    // Reset raised between clock edges must clear state before the next edge.
    task automatic test_async_reset();
        @(posedge w_clk);
        #2 w_rst = 1'b1;
        #1;
        n_checks++; if (w_addr !== '0)     begin n_fail++; $display("FAIL arst_addr: got %0d want 0", w_addr); end
        n_checks++; if (gray_w_ptr !== '0) begin n_fail++; $display("FAIL arst_gray: got %b want 0000", gray_w_ptr); end
        n_checks++; if (w_full !== 1'b0)   begin n_fail++; $display("FAIL arst_full: got %b want 0", w_full); end
        n_checks++; if (w_ovf !== 1'b0)    begin n_fail++; $display("FAIL arst_ovf: got %b want 0", w_ovf); end
`ifdef FIFO_AFULL_EN
        n_checks++; if (w_afull !== 1'b0)  begin n_fail++; $display("FAIL arst_afull: got %b want 0", w_afull); end
`endif
        w_inc      = 1'b0;
        gray_r_ptr = '0;
        model_reset();
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

`ifdef FIFO_AFULL_EN
    task automatic test_afull();
        test_reset();
        m_rd = 0;
        repeat (THRESH - 1) tick(1'b1);
        n_checks++; if (w_afull !== 1'b0) begin n_fail++; $display("FAIL afull_below: got %b want 0", w_afull); end
        tick(1'b1);
        n_checks++; if (w_afull !== 1'b1) begin n_fail++; $display("FAIL afull_at: got %b want 1", w_afull); end
        test_async_reset();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap();
        test_random();
        test_async_reset();
`ifdef FIFO_AFULL_EN
        test_afull();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
